// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder datapath.
//   op_t        : operation select carried with each beat (add / subtract)
//   signed_max  : largest two's-complement value of a given width
//   signed_min  : smallest two's-complement value of a given width
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Widest datapath the saturation limit helpers can describe.
  localparam int unsigned LIMIT_W = 256;

  // 0111...1 in the low w bits.
  function automatic logic [LIMIT_W-1:0] signed_max(input int unsigned w);
    return (LIMIT_W'(1) << (w - 1)) - LIMIT_W'(1);
  endfunction

  // 1000...0 in the low w bits.
  function automatic logic [LIMIT_W-1:0] signed_min(input int unsigned w);
    return LIMIT_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/adder.sv
// Combinational ripple segment adder used as one slice of the pipeline.
//   a_i, b_i : segment operands
//   cin_i    : carry into bit 0
//   sum_c    : segment sum
//   cout_c   : carry out of the segment MSB
//   ovf_c    : signed overflow, treating the segment MSB as a sign bit
module adder #(
  parameter int unsigned INPUT_WIDTH = 8
) (
  input  logic [INPUT_WIDTH-1:0] a_i,
  input  logic [INPUT_WIDTH-1:0] b_i,
  input  logic                   cin_i,
  output logic [INPUT_WIDTH-1:0] sum_c,
  output logic                   cout_c,
  output logic                   ovf_c
);

  localparam int unsigned FULL_W = INPUT_WIDTH + 1;

  logic [INPUT_WIDTH:0] full;

  // Extra MSB captures the carry out.
  assign full   = {1'b0, a_i} + {1'b0, b_i} + FULL_W'(cin_i);
  assign sum_c  = full[INPUT_WIDTH-1:0];
  assign cout_c = full[INPUT_WIDTH];
  // Like-signed operands producing an opposite-signed sum.
  assign ovf_c  = (a_i[INPUT_WIDTH-1] == b_i[INPUT_WIDTH-1]) &&
                  (full[INPUT_WIDTH-1] != b_i[INPUT_WIDTH-1]);

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined signed add/subtract with optional saturation and valid/ready flow.
// Each stage resolves one SEG_WIDTH slice and registers its carry; operand
// slices are skewed in and sum slices deskewed out so a whole beat emerges at
// once, NUM_SEG register levels after it is accepted.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready is combinational)
//   data_ina, data_inb  : signed operands
//   carry_in, op, sat_en: carry into bit 0, add/sub select, saturate enable
//   out_valid/out_ready : result handshake
//   result, carry_out, overflow, zero : registered result and flags
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SEG_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_ina,
  input  logic [WIDTH-1:0] data_inb,
  input  logic             carry_in,
  input  op_t              op,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NUM_SEG = WIDTH / SEG_WIDTH;
  localparam int unsigned LAST    = NUM_SEG - 1;
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(signed_min(WIDTH));

  logic               adv;
  logic [WIDTH-1:0]   bx;
  logic [WIDTH-1:0]   a_stage;
  logic [WIDTH-1:0]   b_stage;
  logic [WIDTH-1:0]   sum_stage;
  logic [WIDTH-1:0]   raw_sum;
  logic [NUM_SEG-1:0] cout_stage;
  logic [NUM_SEG-1:0] cy_q;
  logic [NUM_SEG-1:0] vld_q;
  logic               ovf_last;
  logic               sat_last;
  logic [WIDTH-1:0]   result_d;
  logic [WIDTH-1:0]   result_q;
  logic               zero_d;
  logic               zero_q;
  logic               ovf_q;

  // Whole pipeline moves as one; it only freezes when a result is unread.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[LAST];
  assign carry_out = cy_q[LAST];
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  assign bx = (op == OP_SUB) ? ~data_inb : data_inb;

  // Per-beat valid bits, one per stage; the top bit is the output valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= (vld_q << 1) | NUM_SEG'(in_valid);
    end
  end

  // Inter-stage carries; the top one is the carry out of the full sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cy_q <= '0;
    end else if (adv) begin
      cy_q <= cout_stage;
    end
  end

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    localparam int unsigned LO = k * SEG_WIDTH;

    logic cin_seg;
    logic ovf_seg;

    // Input skew: slice k waits k cycles so it meets its carry.
    if (k == 0) begin : g_head
      assign a_stage[LO +: SEG_WIDTH] = data_ina[LO +: SEG_WIDTH];
      assign b_stage[LO +: SEG_WIDTH] = bx[LO +: SEG_WIDTH];
      assign cin_seg                  = carry_in;
    end else begin : g_skew
      logic [SEG_WIDTH-1:0] a_q [k];
      logic [SEG_WIDTH-1:0] b_q [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < k; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
          end
        end else if (adv) begin
          a_q[0] <= data_ina[LO +: SEG_WIDTH];
          b_q[0] <= bx[LO +: SEG_WIDTH];
          for (int i = 1; i < k; i++) begin
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
          end
        end
      end

      assign a_stage[LO +: SEG_WIDTH] = a_q[k-1];
      assign b_stage[LO +: SEG_WIDTH] = b_q[k-1];
      assign cin_seg                  = cy_q[k-1];
    end

    adder #(
      .INPUT_WIDTH(SEG_WIDTH)
    ) u_adder (
      .a_i   (a_stage[LO +: SEG_WIDTH]),
      .b_i   (b_stage[LO +: SEG_WIDTH]),
      .cin_i (cin_seg),
      .sum_c (sum_stage[LO +: SEG_WIDTH]),
      .cout_c(cout_stage[k]),
      .ovf_c (ovf_seg)
    );

    // Output deskew: earlier slices wait until the top slice is resolved.
    if (k == LAST) begin : g_tail
      assign raw_sum[LO +: SEG_WIDTH] = sum_stage[LO +: SEG_WIDTH];
      assign ovf_last                 = ovf_seg;
    end else begin : g_deskew
      localparam int unsigned DLEN = LAST - k;

      logic [SEG_WIDTH-1:0] s_q [DLEN];
      // Only the top slice's sign overflow means anything for the word.
      logic                 ovf_unused;

      assign ovf_unused = ovf_seg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DLEN; i++) begin
            s_q[i] <= '0;
          end
        end else if (adv) begin
          s_q[0] <= sum_stage[LO +: SEG_WIDTH];
          for (int i = 1; i < DLEN; i++) begin
            s_q[i] <= s_q[i-1];
          end
        end
      end

      assign raw_sum[LO +: SEG_WIDTH] = s_q[DLEN-1];
    end
  end

  // Saturation enable travels with its beat to the top stage.
  if (NUM_SEG == 1) begin : g_sat_direct
    assign sat_last = sat_en;
  end else begin : g_sat_dly
    logic [LAST-1:0] sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sat_q <= '0;
      end else if (adv) begin
        sat_q <= (sat_q << 1) | LAST'(sat_en);
      end
    end

    assign sat_last = sat_q[LAST-1];
  end

  // Clamp toward the sign of A; zero flag follows the clamped value.
  always_comb begin
    result_d = raw_sum;
    if (sat_last && ovf_last) begin
      result_d = a_stage[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
    zero_d = (result_d == '0);
  end

  // Output register for result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (adv) begin
      result_q <= result_d;
      ovf_q    <= ovf_last;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32, SEG_WIDTH=8, four stages).
module tb_pipelined_adder;
  import adder_pkg::*;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned SEG_WIDTH = 8;
  localparam int          NUM_SEG   = 4;
  localparam int          NVEC      = 10000;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_ina = '0;
  logic [31:0] data_inb = '0;
  logic        carry_in = 1'b0;
  op_t         op = OP_ADD;
  logic        sat_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  logic [31:0] va [NVEC];
  logic [31:0] vb [NVEC];
  logic        vcin [NVEC];
  logic        vsub [NVEC];
  logic        vsat [NVEC];
  exp_t        vexp [NVEC];

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  pipelined_adder #(
    .WIDTH    (WIDTH),
    .SEG_WIDTH(SEG_WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_ina (data_ina),
    .data_inb (data_inb),
    .carry_in (carry_in),
    .op       (op),
    .sat_en   (sat_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour of one beat, straight from the arithmetic definition.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub, input logic sat);
    logic [31:0] bxm;
    logic [32:0] s;
    exp_t        e;
    bxm = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bxm} + {32'd0, cin};
    e.c = s[32];
    e.o = (a[31] == bxm[31]) && (s[31] != bxm[31]);
    e.r = (sat && e.o) ? (a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s[31:0];
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic sat,
                         input logic [31:0] r, input logic c, input logic o, input logic z);
    va[i] = a; vb[i] = b; vcin[i] = cin; vsub[i] = sub; vsat[i] = sat;
    vexp[i] = '{r: r, c: c, o: o, z: z};
  endtask

  task automatic set_rand(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(7))
        0:       va[i] = 32'h7FFF_FFFF;
        1:       va[i] = 32'h8000_0000;
        default: va[i] = $urandom;
      endcase
      vb[i]   = ($urandom_range(5) == 0) ? 32'hFFFF_FFFF : $urandom;
      vcin[i] = 1'($urandom_range(1));
      vsub[i] = 1'($urandom_range(1));
      vsat[i] = 1'($urandom_range(1));
      vexp[i] = model(va[i], vb[i], vcin[i], vsub[i], vsat[i]);
    end
  endtask

  task automatic drive(input int i);
    data_ina = va[i];
    data_inb = vb[i];
    carry_in = vcin[i];
    op       = vsub[i] ? OP_SUB : OP_ADD;
    sat_en   = vsat[i];
  endtask

  // Issue n beats; vpct/rpct are percent chances of in_valid/out_ready, and
  // out_ready is forced low for cycles st_lo..st_hi.
  task automatic stream(input int n, input int vpct, input int rpct,
                        input int st_lo, input int st_hi);
    int          i = 0;
    int          cyc = 0;
    logic [31:0] held = '0;
    while (i < n && cyc < n * 10 + 200) begin
      @(posedge clk); #1;
      drive(i);
      in_valid  = ($urandom_range(99) < vpct);
      out_ready = (cyc >= st_lo && cyc <= st_hi) ? 1'b0 : ($urandom_range(99) < rpct);
      @(negedge clk);
      if (cyc >= st_lo && cyc <= st_hi) begin
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_out_valid", out_valid, 1'b1);
        if (cyc > st_lo) chk("stall_hold_result", result, held);
        held = result;
      end
      if (in_valid && in_ready) begin
        sb.push_back(vexp[i]);
        i++;
      end
      cyc++;
    end
    chk("stream_all_issued", i, n);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, sb.size(), 0);
  endtask

  // Single beat into an empty pipe; counts edges from capture to out_valid.
  task automatic lat_beat(input int i);
    int k;
    @(posedge clk); #1;
    drive(i);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", in_ready, 1'b1);
    sb.push_back(vexp[i]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k <= 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency_edges", k, NUM_SEG);
  endtask

  // Monitor: every accepted output beat is matched against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got result %h, expected no beat", result);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.r);
          chk("carry_out", carry_out, e.c);
          chk("overflow", overflow, e.o);
          chk("zero", zero, e.z);
        end
      end
    end
  end

  initial begin
    // Reset state.
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {carry_out, overflow, zero}, 3'b000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors, hand-computed.
    set_vec(0,  32'h0000_00FF, 32'h0000_0001, 0, 0, 0, 32'h0000_0100, 0, 0, 0);
    set_vec(1,  32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h8000_0000, 0, 1, 0);
    set_vec(2,  32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, 32'h7FFF_FFFF, 0, 1, 0);
    set_vec(3,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 32'h8000_0000, 1, 1, 0);
    set_vec(4,  32'h0000_0005, 32'h0000_0005, 1, 1, 0, 32'h0000_0000, 1, 0, 1);
    set_vec(5,  32'h0000_0000, 32'h0000_0001, 1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    set_vec(6,  32'h8000_0000, 32'h0000_0001, 1, 1, 1, 32'h8000_0000, 1, 1, 0);
    set_vec(7,  32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h0000_0000, 1, 0, 1);
    set_vec(8,  32'h0000_0000, 32'h0000_0000, 1, 0, 0, 32'h0000_0001, 0, 0, 0);
    set_vec(9,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 1, 32'h7FFF_FFFF, 0, 1, 0);
    set_vec(10, 32'h00FF_0000, 32'h0000_FFFF, 1, 1, 0, 32'h00FE_0001, 1, 0, 0);
    set_vec(11, 32'h1234_5678, 32'h0EDC_BA98, 0, 0, 0, 32'h2111_1110, 0, 0, 0);

    lat_beat(0);
    drain("drain_latency");
    stream(12, 100, 100, -1, -2);
    drain("drain_directed");

    // Back-to-back with a three-cycle downstream stall.
    set_rand(16);
    stream(16, 100, 100, 6, 8);
    drain("drain_stall");

    // Random valid/ready.
    set_rand(NVEC);
    stream(NVEC, 50, 50, -1, -2);
    drain("drain_random");

    // Reset with four beats in flight: none of them may emerge.
    set_rand(4);
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      drive(j);
      in_valid = 1'b1;
      @(negedge clk);
      chk("fill_in_ready", in_ready, 1'b1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("fill_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_flags", {carry_out, overflow, zero}, 3'b000);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_vec(0, 32'h0000_FFFF, 32'h0000_0001, 0, 0, 0, 32'h0001_0000, 0, 0, 0);
    lat_beat(0);
    drain("drain_after_reset");
    repeat (12) @(posedge clk);
    #1 chk("idle_out_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined signed adder/subtractor for wide datapaths. Operands split into `SEG_WIDTH` segments; each pipeline stage resolves one segment and registers the carry into the next, so the critical path is one segment adder regardless of `WIDTH`. Adds subtract mode, optional signed saturation, a zero flag and valid/ready flow control. Sits between the operand-fetch and write-back stages of the arithmetic datapath and replaces single-cycle wide adds.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must be a multiple of `SEG_WIDTH`.
- `SEG_WIDTH`, 8: bits resolved per pipeline stage; `NUM_SEG = WIDTH/SEG_WIDTH` stages (≥1).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `data_ina`  in  WIDTH  signed operand A.
- `data_inb`  in  WIDTH  signed operand B.
- `carry_in`  in  1  carry into bit 0.
- `op`  in  1  `op_t`: OP_ADD (0) or OP_SUB (1).
- `sat_en`  in  1  1 = clamp signed result on overflow.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  downstream accepts result.
- `result`  out  WIDTH  signed result.
- `carry_out`  out  1  carry out of MSB (pre-saturation).
- `overflow`  out  1  signed overflow (pre-saturation).
- `zero`  out  1  `result` == 0 (post-saturation).

## Operation
- Effective B: `bx = (op == OP_SUB) ? ~data_inb : data_inb`. Sum = A + bx + `carry_in`. Plain subtract: caller drives `carry_in = 1`; `carry_out = 1` means no borrow.
- Stage k (0..NUM_SEG-1) adds segment k of A and bx plus carry from stage k-1 (stage 0 uses `carry_in`); registers segment sum and carry.
- Input skew: segment k of A/bx delayed k cycles before stage k. Output deskew: segment k sum delayed NUM_SEG-1-k cycles so all segments emerge together.
- Overflow: `A[MSB] == bx[MSB]` and `sum[MSB] != bx[MSB]`, evaluated in the last stage; A and bx sign bits travel with the pipeline.
- Saturation (when `sat_en` and overflow): result = `{1'b0, {WIDTH-1{1'b1}}}` if A[MSB]==0, else `{1'b1, {WIDTH-1{1'b0}}}`. `overflow` and `carry_out` still report raw values. `op` and `sat_en` travel with their beat.
- Zero flag computed on the final (post-saturation) result.

## Timing
- Latency: a beat accepted at edge N yields `out_valid` with its result after edge N+NUM_SEG, absent stalls. Throughput: one beat per cycle.
- Global advance enable `adv = !out_valid | out_ready`; all stage registers (data, carries, valid bits) load only when `adv`. `in_ready = adv` (combinational from `out_ready` and `out_valid`).
- Beat transfers in on `in_valid & in_ready`; out on `out_valid & out_ready`. Bubbles (in_valid=0 while advancing) propagate as invalid stages; results never duplicate or drop.
- `out_valid` holds, and `result`/flags stay stable, until `out_ready`.
- Reset (asserting `rst_n` low, any time, including mid-stream): all valid bits, `result`, `carry_out`, `overflow`, `zero`, internal carries → 0 immediately; in-flight beats discarded. `in_ready` = 1 while in reset (out_valid=0). First beat accepted on first edge after deassertion.
- NUM_SEG=1: single registered stage, latency 1, no skew/deskew registers.

## Structure
- `adder_pkg`: `typedef enum logic {OP_ADD, OP_SUB} op_t`; function/constant for signed max/min of a given width.
- Sub-module: existing `adder` base module, instantiated once per segment with `INPUT_WIDTH = SEG_WIDTH` (its overflow output used only for the last segment). Skew/deskew as generate loops of shift registers in this module.

## Test plan (WIDTH=32, SEG_WIDTH=8, latency 4)
- ADD 0x000000FF + 0x00000001, cin=0 → after 4 cycles result 0x00000100, carry_out=0, overflow=0, zero=0 (carry crosses stage boundary).
- ADD 0x7FFFFFFF + 0x00000001: sat_en=0 → 0x80000000, overflow=1; sat_en=1 → 0x7FFFFFFF, overflow=1. ADD 0x80000000 + 0xFFFFFFFF, sat_en=1 → 0x80000000, overflow=1, carry_out=1.
- SUB 0x00000005 − 0x00000005, cin=1 → 0x00000000, zero=1, carry_out=1; SUB 0x00000000 − 0x00000001, cin=1 → 0xFFFFFFFF, carry_out=0.
- 16 back-to-back random beats, out_ready low for 3 cycles mid-stream → in_ready low during stall, output held stable, all 16 results correct and in order vs. model.
- Random in_valid/out_ready (50%) over 10k beats → scoreboard match, no loss/duplication.
- rst_n low for 1 cycle with 4 beats in flight → outputs 0 immediately, none of the 4 beats emerge; next beat after release returns correct result at latency 4.
